// File: rtl/writeback_arbiter_if.sv
// rtl/writeback_arbiter_if.sv - producer and register-file handshake bundle for writeback_arbiter
interface writeback_arbiter_if #(
    parameter int DATABITWIDTH    = 16,
    parameter int INPUTPORTCOUNT  = 4,
    parameter int PORTADDRWIDTH   = 2,
    parameter int REGADDRBITWIDTH = 4
) ();
    logic [INPUTPORTCOUNT-1:0]                      InputACK;
    logic [INPUTPORTCOUNT-1:0]                      InputREQ;
    logic [INPUTPORTCOUNT-1:0][DATABITWIDTH-1:0]    InputData;
    logic [INPUTPORTCOUNT-1:0][REGADDRBITWIDTH-1:0] InputAddr;
    logic                                           OutputACK;
    logic                                           OutputREQ;
    logic [DATABITWIDTH-1:0]                        OutputData;
    logic [REGADDRBITWIDTH-1:0]                     OutputAddr;
    logic [PORTADDRWIDTH-1:0]                       OutputPort;
    logic                                           Urgent;

    modport slave (
        input  InputACK, InputData, InputAddr, OutputREQ,
        output InputREQ, OutputACK, OutputData, OutputAddr, OutputPort, Urgent
    );

    modport master (
        output InputACK, InputData, InputAddr, OutputREQ,
        input  InputREQ, OutputACK, OutputData, OutputAddr, OutputPort, Urgent
    );
endinterface

// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - round-robin writeback arbiter with starvation override and one-entry output register
module writeback_arbiter #(
    parameter int DATABITWIDTH    = 16,
    parameter int INPUTPORTCOUNT  = 4,
    parameter int PORTADDRWIDTH   = 2,
    parameter int REGADDRBITWIDTH = 4,
    parameter int STARVELIMIT     = 7
) (
    input  logic              clk,
    input  logic              async_rst_n,
    input  logic              clk_en,
    writeback_arbiter_if.slave bus
);
    localparam logic [3:0] LIMIT = 4'(STARVELIMIT);

    logic                       out_valid;
    logic [DATABITWIDTH-1:0]    out_data;
    logic [REGADDRBITWIDTH-1:0] out_addr;
    logic [PORTADDRWIDTH-1:0]   out_port;
    logic [PORTADDRWIDTH-1:0]   last_grant;
    logic [3:0]                 wait_cnt [INPUTPORTCOUNT];

    logic                       load;
    logic                       any_ack;
    logic                       transfer;
    logic                       urgent_hit;
    logic                       urgent_any;
    logic [PORTADDRWIDTH-1:0]   urgent_sel;
    logic [PORTADDRWIDTH-1:0]   rr_sel;
    logic [PORTADDRWIDTH-1:0]   grant;
    logic [INPUTPORTCOUNT-1:0]  req;

    assign load     = clk_en && (!out_valid || bus.OutputREQ);
    assign any_ack  = |bus.InputACK;
    assign transfer = load && any_ack;

    // Both scans run downward so the last hit is the lowest index / nearest rotation step.
    always_comb begin
        urgent_hit = 1'b0;
        urgent_any = 1'b0;
        urgent_sel = '0;
        rr_sel     = '0;
        for (int i = INPUTPORTCOUNT - 1; i >= 0; i--) begin
            if (wait_cnt[i] == LIMIT) begin
                urgent_any = 1'b1;
                if (bus.InputACK[i]) begin
                    urgent_hit = 1'b1;
                    urgent_sel = PORTADDRWIDTH'(i);
                end
            end
        end
        for (int k = INPUTPORTCOUNT; k >= 1; k--) begin
            if (bus.InputACK[PORTADDRWIDTH'((int'(last_grant) + k) % INPUTPORTCOUNT)]) begin
                rr_sel = PORTADDRWIDTH'((int'(last_grant) + k) % INPUTPORTCOUNT);
            end
        end
        grant = urgent_hit ? urgent_sel : rr_sel;
    end

    always_comb begin
        req = '0;
        if (transfer) begin
            req[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_addr   <= '0;
            out_port   <= '0;
            last_grant <= PORTADDRWIDTH'(INPUTPORTCOUNT - 1);
            for (int i = 0; i < INPUTPORTCOUNT; i++) begin
                wait_cnt[i] <= '0;
            end
        end else if (clk_en) begin
            if (transfer) begin
                out_valid  <= 1'b1;
                out_data   <= bus.InputData[grant];
                out_addr   <= bus.InputAddr[grant];
                out_port   <= grant;
                last_grant <= grant;
            end else if (bus.OutputREQ) begin
                out_valid <= 1'b0;
            end
            // Waiting ports age even while the output is stalled.
            for (int i = 0; i < INPUTPORTCOUNT; i++) begin
                if (transfer && grant == PORTADDRWIDTH'(i)) begin
                    wait_cnt[i] <= '0;
                end else if (bus.InputACK[i]) begin
                    wait_cnt[i] <= (wait_cnt[i] >= LIMIT) ? LIMIT : wait_cnt[i] + 4'd1;
                end else begin
                    wait_cnt[i] <= '0;
                end
            end
        end
    end

    assign bus.InputREQ   = req;
    assign bus.OutputACK  = out_valid;
    assign bus.OutputData = out_data;
    assign bus.OutputAddr = out_addr;
    assign bus.OutputPort = out_port;
    assign bus.Urgent     = urgent_any;
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb/tb_writeback_arbiter.sv - randomized scoreboard bench for writeback_arbiter
module tb_writeback_arbiter;
    localparam int N   = 4;
    localparam int LIM = 7;

    logic clk = 1'b0;
    logic rst_n;
    logic clk_en;

    always #5 clk = ~clk;

    writeback_arbiter_if #(.DATABITWIDTH(16), .INPUTPORTCOUNT(N), .PORTADDRWIDTH(2), .REGADDRBITWIDTH(4)) bus ();

    writeback_arbiter #(
        .DATABITWIDTH(16), .INPUTPORTCOUNT(N), .PORTADDRWIDTH(2),
        .REGADDRBITWIDTH(4), .STARVELIMIT(LIM)
    ) dut (
        .clk(clk), .async_rst_n(rst_n), .clk_en(clk_en), .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    logic [21:0] sb [$];
    logic [21:0] popped;

    bit          m_valid;
    int          m_last;
    int          m_wait [N];
    logic [15:0] m_data;
    logic [3:0]  m_addr;
    logic [1:0]  m_port;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_last  = N - 1;
        m_data  = '0;
        m_addr  = '0;
        m_port  = '0;
        for (int i = 0; i < N; i++) m_wait[i] = 0;
        sb.delete();
    endtask

    always @(negedge clk) begin
        if (rst_n && clk_en && bus.OutputACK && bus.OutputREQ) begin
            if (sb.size() == 0) begin
                chk("scoreboard_empty_on_consume", 32'd1, 32'd0);
            end else begin
                popped = sb.pop_front();
                chk("sb_data", 32'(bus.OutputData), 32'(popped[15:0]));
                chk("sb_addr", 32'(bus.OutputAddr), 32'(popped[19:16]));
                chk("sb_port", 32'(bus.OutputPort), 32'(popped[21:20]));
            end
        end
    end

    task automatic drive_cycle(input logic [3:0] ack, input bit en, input bit oreq, input bit fixed);
        bit         load;
        bit         urg;
        int         g;
        logic [3:0] exp_req;
        for (int i = 0; i < N; i++) begin
            bus.InputData[i] = 16'($urandom);
            bus.InputAddr[i] = 4'($urandom);
        end
        if (fixed) begin
            bus.InputData[2] = 16'h1234;
            bus.InputAddr[2] = 4'd5;
        end
        bus.InputACK  = ack;
        bus.OutputREQ = oreq;
        clk_en        = en;
        #1;
        load = en && (!m_valid || oreq);
        g = -1;
        for (int i = 0; i < N; i++)
            if (g < 0 && ack[i] && m_wait[i] == LIM) g = i;
        for (int k = 1; k <= N; k++)
            if (g < 0 && ack[(m_last + k) % N]) g = (m_last + k) % N;
        exp_req = (load && g >= 0) ? 4'(1 << g) : 4'b0;
        urg = 1'b0;
        for (int i = 0; i < N; i++) if (m_wait[i] == LIM) urg = 1'b1;
        chk("input_req", 32'(bus.InputREQ), 32'(exp_req));
        chk("output_ack", 32'(bus.OutputACK), 32'(m_valid));
        chk("urgent", 32'(bus.Urgent), 32'(urg));
        chk("output_data", 32'(bus.OutputData), 32'(m_data));
        chk("output_addr", 32'(bus.OutputAddr), 32'(m_addr));
        chk("output_port", 32'(bus.OutputPort), 32'(m_port));
        if (en) begin
            if (load && g >= 0) begin
                m_data  = bus.InputData[g];
                m_addr  = bus.InputAddr[g];
                m_port  = 2'(g);
                m_valid = 1'b1;
                m_last  = g;
                sb.push_back({m_port, m_addr, m_data});
            end else if (oreq) begin
                m_valid = 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                if (load && g == i) m_wait[i] = 0;
                else if (ack[i])    m_wait[i] = (m_wait[i] + 1 > LIM) ? LIM : m_wait[i] + 1;
                else                m_wait[i] = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n         = 1'b0;
        clk_en        = 1'b1;
        bus.InputACK  = '0;
        bus.OutputREQ = 1'b0;
        bus.InputData = '0;
        bus.InputAddr = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        drive_cycle(4'b0000, 1'b1, 1'b1, 1'b0);
        drive_cycle(4'b0100, 1'b1, 1'b1, 1'b1);
        chk("first_word_data", 32'(bus.OutputData), 32'h1234);
        chk("first_word_addr", 32'(bus.OutputAddr), 32'd5);
        chk("first_word_port", 32'(bus.OutputPort), 32'd2);
        drive_cycle(4'b0000, 1'b1, 1'b1, 1'b0);

        for (int c = 0; c < 12; c++) drive_cycle(4'b1111, 1'b1, 1'b1, 1'b0);

        drive_cycle(4'b0010, 1'b1, 1'b1, 1'b0);
        chk("held_from_port1", 32'(bus.OutputPort), 32'd1);
        for (int c = 0; c < 8; c++) drive_cycle(4'b1001, 1'b1, 1'b0, 1'b0);
        chk("urgent_after_stall", 32'(bus.Urgent), 32'd1);
        drive_cycle(4'b1001, 1'b1, 1'b1, 1'b0);
        chk("release_grant_first", 32'(bus.OutputPort), 32'd0);
        drive_cycle(4'b1001, 1'b1, 1'b1, 1'b0);
        chk("release_grant_second", 32'(bus.OutputPort), 32'd3);

        for (int c = 0; c < 3; c++) drive_cycle(4'b1000, 1'b1, 1'b1, 1'b0);
        chk("refill_no_bubble", 32'(bus.OutputACK), 32'd1);

        for (int c = 0; c < 4; c++) drive_cycle(4'b1111, 1'b1, 1'b1, 1'b0);
        for (int c = 0; c < 3; c++) drive_cycle(4'b1111, 1'b0, 1'b1, 1'b0);
        for (int c = 0; c < 4; c++) drive_cycle(4'b1111, 1'b1, 1'b1, 1'b0);

        for (int c = 0; c < 300; c++)
            drive_cycle(4'($urandom), ($urandom_range(9) != 0), ($urandom_range(9) < 7), 1'b0);

        drive_cycle(4'b1111, 1'b1, 1'b1, 1'b0);
        chk("valid_before_reset", 32'(bus.OutputACK), 32'd1);
        bus.InputACK = '0;
        rst_n = 1'b0;
        #1;
        chk("async_reset_clears_ack", 32'(bus.OutputACK), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive_cycle(4'b1111, 1'b1, 1'b1, 1'b0);
        chk("post_reset_grant_port0", 32'(bus.OutputPort), 32'd0);
        drive_cycle(4'b0000, 1'b1, 1'b1, 1'b0);
        drive_cycle(4'b0000, 1'b1, 1'b1, 1'b0);

        chk("scoreboard_drained", 32'(sb.size()), 32'(m_valid));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
